// File: rtl/switch_debounce_if.sv
// Switch-side bundle between the raw pins and the debounced outputs.
// slave is the debouncer's view; master is the consumer/driver's view.
interface switch_debounce_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_out;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             sw_changed;

  modport slave (
    input  sw_raw,
    output sw_out,
    output sw_rise,
    output sw_fall,
    output sw_changed
  );

  modport master (
    output sw_raw,
    input  sw_out,
    input  sw_rise,
    input  sw_fall,
    input  sw_changed
  );
endinterface

// File: rtl/switch_debounce.sv
// Per-bit two-flop synchronizer and stability-counter debouncer for slide switches,
// producing a clean level plus one-cycle rise/fall pulses.
module switch_debounce #(
   parameter int WIDTH           = 10,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic          clk,
   input  logic          reset_n,
   switch_debounce_if.slave sw_if
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync1, sync2;
   logic [WIDTH-1:0] out_q, rise_q, fall_q;
   logic             changed_q;
   logic [CNT_W-1:0] cnt_q [WIDTH];

   logic [CNT_W-1:0] cnt_d [WIDTH];
   logic [WIDTH-1:0] out_d, rise_d, fall_d;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      out_d  = out_q;
      rise_d = '0;
      fall_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (sync2[i] != out_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               out_d[i]  = sync2[i];
               rise_d[i] = sync2[i];
               fall_d[i] = ~sync2[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1     <= '0;
         sync2     <= '0;
         out_q     <= '0;
         rise_q    <= '0;
         fall_q    <= '0;
         changed_q <= 1'b0;
         // NOTE: the counter array is reset explicitly; a partial count must not survive reset.
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      end else begin
         sync1     <= sw_if.sw_raw;
         sync2     <= sync1;
         out_q     <= out_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         changed_q <= |(rise_d | fall_d);
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign sw_if.sw_out     = out_q;
   assign sw_if.sw_rise    = rise_q;
   assign sw_if.sw_fall    = fall_q;
   assign sw_if.sw_changed = changed_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench: a window-based reference model predicts each cycle's outputs,
// a separate monitor pops and compares them against the DUT.
module tb_switch_debounce;

   localparam int W = 10;
   localparam int D = 4;

   typedef struct packed {
      logic [W-1:0] out;
      logic [W-1:0] rise;
      logic [W-1:0] fall;
      logic         changed;
   } exp_t;

   logic clk;
   logic reset_n;

   switch_debounce_if #(.WIDTH(W)) sw_if ();

   switch_debounce #(
      .WIDTH(W),
      .DEBOUNCE_CYCLES(D),
      .CNT_W(20)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .sw_if  (sw_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t exp_q[$];
   int   rise0_cnt = 0;
   logic stim_done = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: a level is accepted once the last D synchronized samples all differ from it.
   logic [W-1:0] hist[$];
   logic [W-1:0] m_out;

   task automatic model_step();
      exp_t         e;
      logic [W-1:0] all_mis;
      if (!reset_n) begin
         hist.delete();
         for (int k = 0; k < D + 2; k++) hist.push_back('0);
         m_out = '0;
         e     = '0;
      end else begin
         all_mis = '1;
         for (int d = 0; d < D; d++) all_mis &= hist[hist.size() - 2 - d] ^ m_out;
         e.rise    = all_mis & ~m_out;
         e.fall    = all_mis & m_out;
         m_out     = m_out ^ all_mis;
         e.out     = m_out;
         e.changed = |all_mis;
         hist.push_back(sw_if.sw_raw);
         void'(hist.pop_front());
      end
      exp_q.push_back(e);
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check("sw_out",     32'(sw_if.sw_out),     32'(e.out));
         check("sw_rise",    32'(sw_if.sw_rise),    32'(e.rise));
         check("sw_fall",    32'(sw_if.sw_fall),    32'(e.fall));
         check("sw_changed", 32'(sw_if.sw_changed), 32'(e.changed));
         if (sw_if.sw_rise[0]) rise0_cnt++;
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      reset_n      = 1'b0;
      sw_if.sw_raw = 10'h3FF;
      step(3);
      check("reset_sw_out",     32'(sw_if.sw_out),     32'h0);
      check("reset_sw_rise",    32'(sw_if.sw_rise),    32'h0);
      check("reset_sw_fall",    32'(sw_if.sw_fall),    32'h0);
      check("reset_sw_changed", 32'(sw_if.sw_changed), 32'h0);
      reset_n = 1'b1;
      step(10);
      check("boot_accept_all", 32'(sw_if.sw_out), 32'h3FF);

      // Clean press of bit 3 from an all-zero level
      sw_if.sw_raw = 10'h000;
      step(10);
      sw_if.sw_raw = 10'h008;
      step(10);
      check("press_bit3", 32'(sw_if.sw_out), 32'h008);

      // Bounce on bit 0: 3 high / 1 low, five times, then stable high
      rise0_cnt = 0;
      for (int r = 0; r < 5; r++) begin
         sw_if.sw_raw[0] = 1'b1;
         step(3);
         check("bounce_hold_low", 32'(sw_if.sw_out[0]), 32'h0);
         sw_if.sw_raw[0] = 1'b0;
         step(1);
      end
      sw_if.sw_raw[0] = 1'b1;
      step(12);
      check("bounce_single_rise", 32'(rise0_cnt), 32'd1);
      check("bounce_settled",     32'(sw_if.sw_out), 32'h009);

      // Release everything, then a simultaneous two-bit press
      sw_if.sw_raw = 10'h000;
      step(10);
      sw_if.sw_raw = 10'h201;
      step(10);
      check("simul_press", 32'(sw_if.sw_out), 32'h201);
      sw_if.sw_raw = 10'h000;
      step(10);

      // Reset in the middle of a bit-5 count
      sw_if.sw_raw = 10'h020;
      step(3);
      reset_n = 1'b0;
      step(1);
      reset_n = 1'b1;
      step(D + 1);
      check("midreset_not_yet", 32'(sw_if.sw_out), 32'h000);
      step(3);
      check("midreset_accept", 32'(sw_if.sw_out), 32'h020);

      // Randomized bouncing with occasional resets
      for (int c = 0; c < 600; c++) begin
         logic [W-1:0] flips;
         flips = '0;
         for (int b = 0; b < W; b++) flips[b] = ($urandom_range(0, 7) == 0);
         sw_if.sw_raw = sw_if.sw_raw ^ flips;
         reset_n      = ($urandom_range(0, 149) != 0);
         step(1);
      end
      reset_n = 1'b1;
      step(12);
      stim_done = 1'b1;
   end

   initial begin
      fork
         wait (stim_done);
         #200000;
      join_any
      if (!stim_done) check("timeout", 32'd1, 32'd0);
      @(posedge clk);
      #2;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/switch_debounce.md
# switch_debounce

Per-bit synchronizer and debouncer for the board slide switches. Takes the raw, asynchronous, bouncing switch pins and produces a clean, clock-synchronous switch vector that drives the `in_port` of the 10-bit switch PIO slave, plus one-cycle rise/fall pulses for logic that needs change events. Each bit is debounced independently with its own stability counter.

## Interface

Parameters:

- `WIDTH`, default 10: number of switch bits.
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable samples required to accept a new level (10 ms at 50 MHz). Legal range is 1 to 2^CNT_W.
- `CNT_W`, default 20: width of each per-bit counter.

Ports:

- `clk`, in, 1: system clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `sw_raw`, in, WIDTH: raw switch pins, asynchronous to `clk`.
- `sw_out`, out, WIDTH: debounced level. Feeds the PIO `in_port`.
- `sw_rise`, out, WIDTH: one-cycle pulse when `sw_out[i]` goes 0→1.
- `sw_fall`, out, WIDTH: one-cycle pulse when `sw_out[i]` goes 1→0.
- `sw_changed`, out, 1: OR of all `sw_rise` and `sw_fall` bits, registered in the same cycle as the pulses.

## Operation

- **Reset values.** All of the following are 0: `sync1`, `sync2`, every `cnt[i]`, `sw_out`, `sw_rise`, `sw_fall`, `sw_changed`.
- **Synchronizer.** Each bit passes through a two-flop chain: `sync1 <= sw_raw`, `sync2 <= sync1`. Only `sync2` is used downstream.
- **Per-bit counter.** On every clock edge, for each bit i:
  - `sync2[i] == sw_out[i]`: `cnt[i] <= 0`. No change.
  - Mismatch and `cnt[i] == DEBOUNCE_CYCLES-1`: `sw_out[i] <= sync2[i]`, `cnt[i] <= 0`, and pulse `sw_rise[i]` or `sw_fall[i]` according to the new value.
  - Mismatch otherwise: `cnt[i] <= cnt[i] + 1`.
- **Bounce rejection.** Any return of `sync2[i]` to the `sw_out[i]` level before the count completes clears the counter. Only DEBOUNCE_CYCLES consecutive mismatched samples are accepted.
- **Pulses.** `sw_rise` and `sw_fall` are registered and default to 0 each cycle, so each pulse lasts exactly one cycle. `sw_rise[i]` and `sw_fall[i]` are never high together.
- **Independence.** Bits are fully independent. Simultaneous transitions on several bits produce simultaneous pulses and a single-cycle `sw_changed`.
- **Counter width.** The counter never exceeds DEBOUNCE_CYCLES-1, so it cannot wrap.
- **Special case.** With DEBOUNCE_CYCLES = 1, the first mismatched sample is accepted immediately.
- **After reset.** `sw_out` starts at 0. Any switch that is already high is accepted after the normal debounce latency and generates a `sw_rise` pulse. This is required behaviour; software clears any edge state after boot.
- **Reset mid-operation.** Asserting `reset_n` low immediately clears all state, including partial counts. Debouncing restarts from zero after release.

## Timing

- Let `sw_raw[i]` change before edge k and then stay stable:
  - edge k: `sync1` updated;
  - edge k+1: `sync2` updated;
  - edges k+2 … k+1+D: D mismatched samples, where D = DEBOUNCE_CYCLES;
  - edge k+1+D: `sw_out[i]` and the pulse update.
- Total latency is D+2 clocks from the first sampling edge.
- The pulses coincide with the `sw_out` change and drop at the next edge.
- The PIO adds one more register stage, so readdata reflects the switch at edge k+2+D.
- Outputs are pure registers with no combinational path from inputs.

## Test plan

Bench setting: DEBOUNCE_CYCLES = 4, WIDTH = 10.

1. **Reset.** Hold `reset_n` = 0 with `sw_raw` = 10'h3FF → all outputs read 0. Release reset → `sw_out` = 10'h3FF after edge k+5, `sw_rise` = 10'h3FF for exactly 1 cycle, `sw_changed` = 1 for 1 cycle.
2. **Clean press.** With `sw_out` = 0, step `sw_raw[3]` to 1 before edge k → `sw_out` = 10'h008 after edge k+5, `sw_rise[3]` pulses for one cycle, `sw_fall` stays 0.
3. **Bounce rejection.** Toggle `sw_raw[0]` with a high time of 3 cycles and a low time of 1 cycle, repeated 5 times, then hold it high → `sw_out[0]` stays 0 throughout the bouncing. It rises exactly 6 edges after the final stable-high sampling edge, with only one `sw_rise[0]` pulse.
4. **Release.** With `sw_out` = 10'h008, drop `sw_raw[3]` → `sw_out` = 0 after D+2 edges, `sw_fall[3]` pulses once, `sw_rise` stays 0.
5. **Simultaneous bits.** Change `sw_raw` from 10'h000 to 10'h201 in one step → both bits update on the same edge, `sw_rise` = 10'h201 for one cycle, and `sw_changed` pulses once.
6. **Reset mid-count.** Make bit 5 mismatch for 3 cycles, assert `reset_n` for 1 cycle, then release with `sw_raw[5]` still 1 → all state clears. `sw_out[5]` rises only after a full D+2 edges following release.
